// File: rtl/inst_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/response, PC redirect,
// and the valid/ready instruction handoff to decode.
interface inst_fetch_unit_if #(
  parameter int unsigned BIN_DIG = 32
);
  logic               imem_req_valid;
  logic               imem_req_ready;
  logic [BIN_DIG-1:0] imem_req_addr;
  logic               imem_resp_valid;
  logic [BIN_DIG-1:0] imem_resp_data;
  logic               redirect_valid;
  logic [BIN_DIG-1:0] redirect_pc;
  logic               inst_valid;
  logic               inst_ready;
  logic [BIN_DIG-1:0] inst_addr;
  logic [BIN_DIG-1:0] curr_inst;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_addr, curr_inst,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_addr, curr_inst,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, inst_ready
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, keeps one memory request in flight and
// buffers returned words in a small FIFO with a registered head for decode.
module inst_fetch_unit #(
  parameter int unsigned        BIN_DIG    = 32,
  parameter logic [BIN_DIG-1:0] RESET_PC   = '0,
  parameter int unsigned        IBUF_DEPTH = 2
) (
  input  logic                CLK,
  input  logic                RST,
  inst_fetch_unit_if.master   bus
);

  localparam int unsigned PTR_W = $clog2(IBUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(IBUF_DEPTH);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t             state_q, state_d;
  logic [BIN_DIG-1:0] pc_q, pc_d;
  logic [BIN_DIG-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic               req_valid_q, req_valid_d;
  logic               inst_valid_q, inst_valid_d;
  logic [BIN_DIG-1:0] head_addr_q, head_addr_d;
  logic [BIN_DIG-1:0] head_inst_q, head_inst_d;
  logic               fire, push, pop;

  logic [BIN_DIG-1:0] mem_inst [IBUF_DEPTH];
  logic [BIN_DIG-1:0] mem_addr [IBUF_DEPTH];

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    head_addr_d = head_addr_q;
    head_inst_d = head_inst_q;
    fire        = req_valid_q && bus.imem_req_ready;
    push        = 1'b0;
    pop         = inst_valid_q && bus.inst_ready;

    case (state_q)
      S_REQ: if (fire) begin
        req_pc_d = pc_q;
        pc_d     = pc_q + BIN_DIG'(4);
        state_d  = S_WAIT;
      end
      S_WAIT: if (bus.imem_resp_valid) begin
        push    = 1'b1;
        state_d = S_REQ;
      end
      S_DROP: if (bus.imem_resp_valid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase

    // A request accepted or still outstanding at redirect must have its
    // response swallowed in DROP; a response arriving with the redirect is
    // simply not pushed.
    if (bus.redirect_valid) begin
      pc_d = bus.redirect_pc & ~BIN_DIG'(3);
      push = 1'b0;
      pop  = 1'b0;
      case (state_q)
        S_REQ:   state_d = fire ? S_DROP : S_REQ;
        S_WAIT:  state_d = bus.imem_resp_valid ? S_REQ : S_DROP;
        S_DROP:  state_d = bus.imem_resp_valid ? S_REQ : S_DROP;
        default: state_d = S_REQ;
      endcase
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (bus.redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end

    // Head is loaded from the slot it will occupy next cycle; when that slot
    // is the one being written now, bypass the incoming word.
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        head_addr_d = req_pc_q;
        head_inst_d = bus.imem_resp_data;
      end else begin
        head_addr_d = mem_addr[rd_ptr_d];
        head_inst_d = mem_inst[rd_ptr_d];
      end
    end

    inst_valid_d = (count_d != '0);
    req_valid_d  = (state_d == S_REQ) && (count_d < DEPTH_C);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      head_addr_q  <= '0;
      head_inst_q  <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
      head_addr_q  <= head_addr_d;
      head_inst_q  <= head_inst_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_inst[wr_ptr_q] <= bus.imem_resp_data;
      mem_addr[wr_ptr_q] <= req_pc_q;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst_addr      = head_addr_q;
  assign bus.curr_inst      = head_inst_q;

  a_no_resp_in_req: assert property (@(posedge CLK) disable iff (!RST)
    !(bus.imem_resp_valid && (state_q == S_REQ)));
  a_addr_aligned: assert property (@(posedge CLK) disable iff (!RST)
    (bus.imem_req_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: a variable-latency memory responder
// stepped by tick(), with decode-side and request-side expectations as constants.
module tb_inst_fetch_unit;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  inst_fetch_unit_if #(.BIN_DIG(32)) bus ();

  inst_fetch_unit #(
    .BIN_DIG   (32),
    .RESET_PC  (32'h0),
    .IBUF_DEPTH(2)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.master)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  int unsigned n_cons = 0;

  logic [31:0] exp_q[$];
  logic [31:0] req_log[$];

  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  int unsigned lat_cnt = 0;
  int unsigned mem_lat = 1;
  logic        toggle_ready = 1'b0;
  logic        last_acc = 1'b0;
  logic [31:0] last_acc_addr = '0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, then update the memory model.
  task automatic tick();
    logic acc, rsp, cons;
    logic [31:0] a_addr, c_addr, c_inst, e;
    acc    = bus.imem_req_valid && bus.imem_req_ready;
    a_addr = bus.imem_req_addr;
    rsp    = bus.imem_resp_valid;
    cons   = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;
    c_addr = bus.inst_addr;
    c_inst = bus.curr_inst;
    @(posedge CLK);
    @(negedge CLK);
    last_acc      = acc;
    last_acc_addr = a_addr;
    if (acc) req_log.push_back(a_addr);
    if (cons) begin
      n_cons++;
      if (exp_q.size() == 0) begin
        chk("inst_unexpected_pending", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("inst_addr", c_addr, e);
        chk("curr_inst", c_inst, word(e));
      end
    end
    if (rsp) bus.imem_resp_valid = 1'b0;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = a_addr;
      lat_cnt   = mem_lat;
    end
    if (pend) begin
      lat_cnt--;
      if (lat_cnt == 0) begin
        pend                = 1'b0;
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = word(pend_addr);
      end
    end
    if (toggle_ready) bus.imem_req_ready = ~bus.imem_req_ready;
  endtask

  task automatic do_reset();
    RST                 = 1'b0;
    pend                = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.imem_req_ready  = 1'b1;
    toggle_ready        = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    RST = 1'b1;
  endtask

  task automatic run_until_cons(input string tag, input int unsigned target,
                                input int unsigned budget);
    for (int unsigned i = 0; i < budget && n_cons < target; i++) tick();
    chk(tag, 32'(n_cons), 32'(target));
  endtask

  task automatic run_until_req(input string tag, input logic [31:0] addr,
                               input int unsigned budget);
    logic got;
    got = 1'b0;
    for (int unsigned i = 0; i < budget && !got; i++) begin
      tick();
      if (last_acc && last_acc_addr == addr) got = 1'b1;
    end
    chk(tag, {31'd0, got}, 32'd1);
  endtask

  task automatic redirect(input logic [31:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nb;
    logic [31:0] t5_exp [5];
    t5_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};

    bus.imem_req_ready  = 1'b1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.inst_ready      = 1'b1;

    // Reset state
    #2;
    chk("rst_req_valid",  {31'd0, bus.imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("rst_inst_addr",  bus.inst_addr, 32'h0);
    chk("rst_curr_inst",  bus.curr_inst, 32'h0);
    chk("rst_req_addr",   bus.imem_req_addr, 32'h0);
    @(negedge CLK);
    repeat (2) tick();
    RST = 1'b1;
    chk("rel_req_valid_low", {31'd0, bus.imem_req_valid}, 32'd0);
    tick();
    chk("rel_req_valid_high", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("rel_req_addr", bus.imem_req_addr, 32'h0);

    // 1: latency 1, decode always ready
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
    run_until_cons("t1_stream_done", n_cons + 4, 40);

    // 2: decode stalled fills the buffer, then drains in order
    bus.inst_ready = 1'b0;
    do_reset();
    nb = req_log.size();
    repeat (10) tick();
    chk("t2_req_count", 32'(req_log.size() - nb), 32'd2);
    chk("t2_req0", req_log[nb], 32'h0);
    chk("t2_req1", req_log[nb+1], 32'h4);
    chk("t2_full_req_valid", {31'd0, bus.imem_req_valid}, 32'd0);
    chk("t2_head_valid", {31'd0, bus.inst_valid}, 32'd1);
    chk("t2_head_addr", bus.inst_addr, 32'h0);
    chk("t2_head_inst", bus.curr_inst, word(32'h0));
    exp_q = '{32'h0, 32'h4, 32'h8};
    bus.inst_ready = 1'b1;
    run_until_cons("t2_drain_done", n_cons + 3, 40);
    chk("t2_resume_addr", req_log[nb+2], 32'h8);

    // 3: redirect while waiting on 0x8
    mem_lat = 3;
    do_reset();
    exp_q = '{32'h0, 32'h4};
    run_until_req("t3_req8_seen", 32'h8, 40);
    chk("t3_pre_drained", 32'(exp_q.size()), 32'd0);
    nb = req_log.size();
    exp_q = '{32'h100, 32'h104};
    redirect(32'h100);
    run_until_req("t3_req100_seen", 32'h100, 40);
    chk("t3_next_req_is_100", 32'(req_log.size()), 32'(nb + 1));
    run_until_cons("t3_stream_done", n_cons + 2, 40);

    // 4: redirect coinciding with the response
    mem_lat = 1;
    do_reset();
    exp_q = '{32'h0};
    run_until_req("t4_req4_seen", 32'h4, 40);
    chk("t4_pre_drained", 32'(exp_q.size()), 32'd0);
    nb = req_log.size();
    exp_q = '{32'h200, 32'h204};
    redirect(32'h203);
    chk("t4_empty_after", {31'd0, bus.inst_valid}, 32'd0);
    chk("t4_req_valid", {31'd0, bus.imem_req_valid}, 32'd1);
    chk("t4_req_addr", bus.imem_req_addr, 32'h200);
    run_until_req("t4_req200_seen", 32'h200, 10);
    chk("t4_next_req_is_200", 32'(req_log.size()), 32'(nb + 1));
    run_until_cons("t4_stream_done", n_cons + 2, 40);

    // 5: PC wrap, latency 5, request-ready toggling
    mem_lat = 5;
    do_reset();
    toggle_ready = 1'b1;
    redirect(32'hFFFF_FFF8);
    nb = req_log.size();
    exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    run_until_cons("t5_stream_done", n_cons + 5, 300);
    for (int i = 0; i < 5; i++) chk("t5_req_seq", req_log[nb + i], t5_exp[i]);

    // 6: reset while waiting; the stale response lands during reset
    toggle_ready       = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b0;
    run_until_req("t6_req10_seen", 32'h10, 80);
    chk("t6_pre_head_valid", {31'd0, bus.inst_valid}, 32'd1);
    #2;
    RST = 1'b0;
    #1;
    chk("t6_rst_req_valid",  {31'd0, bus.imem_req_valid}, 32'd0);
    chk("t6_rst_inst_valid", {31'd0, bus.inst_valid}, 32'd0);
    chk("t6_rst_inst_addr",  bus.inst_addr, 32'h0);
    chk("t6_rst_curr_inst",  bus.curr_inst, 32'h0);
    chk("t6_rst_req_addr",   bus.imem_req_addr, 32'h0);
    repeat (8) tick();
    RST = 1'b1;
    nb = req_log.size();
    exp_q = '{32'h0, 32'h4};
    bus.inst_ready = 1'b1;
    run_until_cons("t6_stream_done", n_cons + 2, 40);
    chk("t6_first_req", req_log[nb], 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
